// File: rtl/ram2p_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram2p_fifo_pkg
// Description : Shared defaults and types for the two-port-RAM FIFO
//               controller (RAM geometry, pointer and data word types).
// Revision    : 1.0 - initial release
// ============================================================================
package ram2p_fifo_pkg;

  // Default RAM geometry: 256 entries of 116 bits.
  localparam int RAM2P_DEPTH  = 256;
  localparam int RAM2P_WIDTH  = 116;
  localparam int RAM2P_ADDR_W = 8;

  // Pointer carries one extra wrap bit so full and empty are distinguishable.
  typedef logic [RAM2P_ADDR_W:0]   ptr_t;

  // One FIFO word as stored in the RAM.
  typedef logic [RAM2P_WIDTH-1:0]  data_t;

endpackage
`default_nettype wire

// File: rtl/ram2p_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ram2p_fifo_ctrl_if
// Description : Push/pop valid-ready stream bundle of the FIFO controller.
//               master = producer/consumer side, slave = FIFO side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram2p_fifo_ctrl_if
  import ram2p_fifo_pkg::*;
#(
  parameter int WIDTH = RAM2P_WIDTH
) ();

  logic             pushValid;
  logic             pushReady;
  logic [WIDTH-1:0] pushData;
  logic             popValid;
  logic             popReady;
  logic [WIDTH-1:0] popData;

  modport master (
    output pushValid, pushData, popReady,
    input  pushReady, popValid, popData
  );

  modport slave (
    input  pushValid, pushData, popReady,
    output pushReady, popValid, popData
  );

endinterface
`default_nettype wire

// File: rtl/ram2p_fifo_ctrl_outstage.sv
`default_nettype none
// ============================================================================
// Module      : ram2p_fifo_outstage
// Description : Two-entry show-ahead output stage (out + skid register).
//               Accepts one word per cycle on in_valid and presents the
//               oldest word on pop_data with a valid/ready handshake.
//               The caller guarantees in_valid never arrives when both
//               slots stay occupied through the cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ram2p_fifo_outstage
  import ram2p_fifo_pkg::*;
#(
  parameter int WIDTH = RAM2P_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       stage_count
);

  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             pop_fire;

  assign pop_fire = out_valid & pop_ready;

  // Keep the oldest word in out; the skid slot only ever holds the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      if (pop_fire) begin
        if (skid_valid) begin
          // Skid advances; a new arrival refills the skid slot.
          out_data <= skid_data;
          if (in_valid) begin
            skid_data <= in_data;
          end else begin
            skid_valid <= 1'b0;
          end
        end else if (in_valid) begin
          // Single entry replaced directly by the arriving word.
          out_data <= in_data;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (in_valid) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_data  <= in_data;
        end else begin
          skid_valid <= 1'b1;
          skid_data  <= in_data;
        end
      end
    end
  end

  assign pop_valid   = out_valid;
  assign pop_data    = out_data;
  assign stage_count = {1'b0, out_valid} + {1'b0, skid_valid};

endmodule
`default_nettype wire

// File: rtl/ram2p_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram2p_fifo_ctrl
// Description : Synchronous FIFO controller around an external two-port RAM
//               (one write port, one registered read port, 1-cycle read
//               latency). Presents a show-ahead valid/ready pop stream with
//               full throughput using a 2-entry output stage.
//               Optional feature macro: RAM2P_FIFO_CTRL_BYPASS_EN
//               (when defined, a push into an empty FIFO skips the RAM and
//               reaches popValid one edge after acceptance).
// Revision    : 1.0 - initial release
// ============================================================================
module ram2p_fifo_ctrl
  import ram2p_fifo_pkg::*;
#(
  parameter int DEPTH  = RAM2P_DEPTH,
  parameter int WIDTH  = RAM2P_WIDTH,
  parameter int ADDR_W = RAM2P_ADDR_W
) (
  input  logic              clockCore,
  input  logic              resetCoreN,
  ram2p_fifo_ctrl_if.slave  bus,
  output logic [ADDR_W:0]   count,
  output logic              ramEnableWrite,
  output logic [ADDR_W-1:0] ramAddressWrite,
  output logic [WIDTH-1:0]  ramWriteData,
  output logic              ramEnableRead,
  output logic [ADDR_W-1:0] ramAddressRead,
  input  logic [WIDTH-1:0]  ramReadData
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

  // Pointers and occupancy of the RAM portion only.
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic [ADDR_W:0]  wr_ptr_next;
  logic [ADDR_W:0]  rd_ptr_next;
  logic [ADDR_W:0]  mem_count;
  logic [ADDR_W:0]  mem_count_next;

  logic             push_ready_q;
  logic             in_flight;
  logic             push_fire;
  logic             pop_fire;
  logic             ram_write;
  logic             read_issue;
  logic             bypass_take;
  logic             stage_room;
  logic [1:0]       stage_count;
  logic [2:0]       stage_load;
  logic [WIDTH-1:0] stage_in_data;

  assign mem_count = wr_ptr - rd_ptr;
  assign push_fire = bus.pushValid & push_ready_q;
  assign pop_fire  = bus.popValid & bus.popReady;

  // Words already committed to the stage plus the one travelling from the
  // RAM; a new word may be launched only if it will have a slot to land in.
  // "load - pop_fire < 2" is written as "load < 2 + pop_fire" to stay unsigned.
  assign stage_load = {1'b0, stage_count} + {2'b00, in_flight};
  assign stage_room = (stage_load < (3'd2 + {2'b00, pop_fire}));
  assign read_issue = (mem_count != '0) && stage_room;

`ifdef RAM2P_FIFO_CTRL_BYPASS_EN
  // The in-flight slot also carries bypassed words so the stage sees one
  // uniform arrival path and ordering cannot be violated.
  logic             byp_flight;
  logic [WIDTH-1:0] byp_data;

  assign bypass_take = push_fire && (mem_count == '0) && !in_flight && stage_room;

  // Capture the bypassed push so it lands in the stage on the next edge.
  always_ff @(posedge clockCore or negedge resetCoreN) begin
    if (!resetCoreN) begin
      byp_flight <= 1'b0;
      byp_data   <= '0;
    end else begin
      byp_flight <= bypass_take;
      if (bypass_take) begin
        byp_data <= bus.pushData;
      end
    end
  end

  assign stage_in_data = byp_flight ? byp_data : ramReadData;
`else
  assign bypass_take   = 1'b0;
  assign stage_in_data = ramReadData;
`endif

  assign ram_write      = push_fire & ~bypass_take;
  assign wr_ptr_next    = wr_ptr + {{ADDR_W{1'b0}}, ram_write};
  assign rd_ptr_next    = rd_ptr + {{ADDR_W{1'b0}}, read_issue};
  assign mem_count_next = wr_ptr_next - rd_ptr_next;

  // Pointer, in-flight and registered push-ready bookkeeping.
  always_ff @(posedge clockCore or negedge resetCoreN) begin
    if (!resetCoreN) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      in_flight    <= 1'b0;
      push_ready_q <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      in_flight    <= read_issue | bypass_take;
      // Registered from the RAM level only: a pop at full frees a slot
      // one edge later, never in the same cycle.
      push_ready_q <= (mem_count_next < FULL_LEVEL);
    end
  end

  // Total occupancy: every accepted push adds one, every pop removes one.
  always_ff @(posedge clockCore or negedge resetCoreN) begin
    if (!resetCoreN) begin
      count <= '0;
    end else begin
      count <= count + {{ADDR_W{1'b0}}, push_fire} - {{ADDR_W{1'b0}}, pop_fire};
    end
  end

  ram2p_fifo_outstage #(
    .WIDTH (WIDTH)
  ) u_outstage (
    .clk         (clockCore),
    .rst_n       (resetCoreN),
    .in_valid    (in_flight),
    .in_data     (stage_in_data),
    .pop_valid   (bus.popValid),
    .pop_ready   (bus.popReady),
    .pop_data    (bus.popData),
    .stage_count (stage_count)
  );

  assign bus.pushReady   = push_ready_q;

  assign ramEnableWrite  = ram_write;
  assign ramAddressWrite = wr_ptr[ADDR_W-1:0];
  assign ramWriteData    = ram_write ? bus.pushData : '0;

  assign ramEnableRead   = read_issue;
  assign ramAddressRead  = rd_ptr[ADDR_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_ram2p_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram2p_fifo_ctrl
// Description : Self-checking bench for ram2p_fifo_ctrl with a behavioural
//               RAM and a queue-based reference of the FIFO contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram2p_fifo_ctrl;
  import ram2p_fifo_pkg::*;

  localparam int DEPTH  = RAM2P_DEPTH;
  localparam int WIDTH  = RAM2P_WIDTH;
  localparam int ADDR_W = RAM2P_ADDR_W;
`ifdef RAM2P_FIFO_CTRL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ram2p_fifo_ctrl_if #(.WIDTH(WIDTH)) bus ();

  logic [ADDR_W:0]   count;
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] aw;
  logic [ADDR_W-1:0] ar;
  data_t             wd;
  data_t             rdata;

  ram2p_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clockCore       (clk),
    .resetCoreN      (rst_n),
    .bus             (bus),
    .count           (count),
    .ramEnableWrite  (we),
    .ramAddressWrite (aw),
    .ramWriteData    (wd),
    .ramEnableRead   (re),
    .ramAddressRead  (ar),
    .ramReadData     (rdata)
  );

  // External two-port RAM with registered read.
  data_t mem [DEPTH];
  always @(posedge clk) begin
    if (we) mem[aw] <= wd;
    if (re) rdata <= mem[ar];
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: FIFO contents as a queue; RAM addresses must advance by one.
  data_t model_q[$];
  bit    sb_on = 1'b0;
  int    exp_aw = 0, exp_ar = 0, wr_wraps = 0, rd_wraps = 0;

  always @(negedge clk) begin
    if (sb_on && rst_n) begin
      check("count_vs_model", count, model_q.size());
      if (bus.popValid && bus.popReady) begin
        if (model_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL pop_from_empty: got popData %0h required no pop", bus.popData);
        end else begin
          check("pop_order", bus.popData, model_q[0]);
          void'(model_q.pop_front());
        end
      end
      if (bus.pushValid && bus.pushReady) model_q.push_back(bus.pushData);
      if (we) begin
        check("wr_addr_seq", aw, exp_aw);
        if (int'(aw) == DEPTH-1) wr_wraps++;
        exp_aw = (exp_aw + 1) % DEPTH;
      end
      if (re) begin
        check("rd_addr_seq", ar, exp_ar);
        if (int'(ar) == DEPTH-1) rd_wraps++;
        exp_ar = (exp_ar + 1) % DEPTH;
      end
    end
  end

  task automatic do_reset();
    sb_on = 1'b0;
    bus.pushValid = 1'b0;
    bus.popReady  = 1'b0;
    bus.pushData  = '0;
    rst_n = 1'b0;
    #1;
    check("rst_push_ready", bus.pushReady, 0);
    check("rst_pop_valid", bus.popValid, 0);
    check("rst_pop_data", bus.popData, 0);
    check("rst_count", count, 0);
    check("rst_ram_we", we, 0);
    check("rst_ram_re", re, 0);
    repeat (3) tick();
    model_q.delete();
    exp_aw = 0;
    exp_ar = 0;
    rst_n = 1'b1;
    sb_on = 1'b1;
  endtask

  typedef struct {
    bit          pv;
    logic [15:0] pd;
    bit          pr;
    bit          e_prdy;
    bit          e_pv;
    logic [15:0] e_pd;
    int          e_cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   accepted, low_run, cnt_at_drop, sent, popped, gaps, first_cnt, cnt_changes;
    bit   pf;
    data_t tmp;

    bus.pushValid = 1'b0;
    bus.popReady  = 1'b0;
    bus.pushData  = '0;
    #2;
    do_reset();

    // ---- Table: single push latency, pop, then a two-word burst ----------
    vecs[0] = '{0, 16'h0,    0, 1, 0,   16'h0,    0};
    vecs[1] = '{1, 16'h1234, 0, 1, 0,   16'h0,    1};
    vecs[2] = '{0, 16'h0,    0, 1, BYP, 16'h1234, 1};
    vecs[3] = '{0, 16'h0,    0, 1, 1,   16'h1234, 1};
    vecs[4] = '{0, 16'h0,    1, 1, 0,   16'h0,    0};
    vecs[5] = '{1, 16'h00A1, 0, 1, 0,   16'h0,    1};
    vecs[6] = '{1, 16'h00A2, 0, 1, BYP, 16'h00A1, 2};
    vecs[7] = '{0, 16'h0,    0, 1, 1,   16'h00A1, 2};
    vecs[8] = '{0, 16'h0,    1, 1, 1,   16'h00A2, 1};
    vecs[9] = '{0, 16'h0,    1, 1, 0,   16'h0,    0};
    for (int i = 0; i < 10; i++) begin
      bus.pushValid = vecs[i].pv;
      bus.pushData  = '0;
      bus.pushData[15:0] = vecs[i].pd;
      bus.popReady  = vecs[i].pr;
      tick();
      check($sformatf("vec%0d_push_ready", i), bus.pushReady, vecs[i].e_prdy);
      check($sformatf("vec%0d_pop_valid", i), bus.popValid, vecs[i].e_pv);
      check($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
      if (vecs[i].e_pv) check($sformatf("vec%0d_pop_data", i), bus.popData, vecs[i].e_pd);
    end
    bus.pushValid = 1'b0;
    bus.popReady  = 1'b0;
    tick();

    // ---- Fill to full with popReady low: RAM full plus 2 stage entries ----
    accepted = 0; low_run = 0; cnt_at_drop = -1;
    for (int c = 0; c < 2000 && low_run < 4; c++) begin
      bus.pushValid = 1'b1;
      bus.pushData  = data_t'(c + 'h100000);
      @(negedge clk);
      if (bus.pushReady) accepted++;
      tick();
      if (!bus.pushReady) begin
        if (low_run == 0) cnt_at_drop = int'(count);
        low_run++;
      end else begin
        low_run = 0;
      end
    end
    check("full_accepted", accepted, DEPTH + 2);
    check("full_count_at_drop", cnt_at_drop, DEPTH + 2);
    check("full_push_ready", bus.pushReady, 0);

    // Pop one at full while still pushing: push blocked, ready returns.
    bus.pushValid = 1'b1;
    bus.pushData  = data_t'('hDEAD);
    bus.popReady  = 1'b1;
    @(negedge clk);
    pf = bus.pushValid & bus.pushReady;
    check("full_push_blocked", pf, 0);
    tick();
    bus.pushValid = 1'b0;
    bus.popReady  = 1'b0;
    check("full_ready_reassert", bus.pushReady, 1);
    check("full_count_after_pop", count, DEPTH + 1);

    // Drain.
    bus.popReady = 1'b1;
    for (int c = 0; c < 1000 && count != 0; c++) tick();
    bus.popReady = 1'b0;
    check("drain_count", count, 0);
    check("drain_model", model_q.size(), 0);

    // ---- Continuous stream 0..999, popReady held high --------------------
    sent = 0; popped = 0; gaps = 0; first_cnt = -1; cnt_changes = 0;
    bus.popReady = 1'b1;
    for (int c = 0; c < 3000 && popped < 1000; c++) begin
      bus.pushValid = (sent < 1000);
      bus.pushData  = data_t'(sent);
      @(negedge clk);
      if (bus.pushValid && bus.pushReady) sent++;
      if (bus.popValid) popped++;
      else if (popped > 0 && popped < 1000) gaps++;
      if (popped > 0 && sent < 1000) begin
        if (first_cnt < 0) first_cnt = int'(count);
        else if (int'(count) != first_cnt) cnt_changes++;
      end
      tick();
    end
    bus.pushValid = 1'b0;
    check("stream_popped", popped, 1000);
    check("stream_bubbles", gaps, 0);
    check("stream_count_steady", cnt_changes, 0);

    // ---- Random push/pop with stalls across the address wrap -------------
    sent = 0; wr_wraps = 0; rd_wraps = 0;
    for (int c = 0; c < 20000 && !(sent == 600 && model_q.size() == 0); c++) begin
      bus.pushValid = (sent < 600) && ($urandom_range(3) != 0);
      tmp = data_t'({$urandom(), $urandom(), $urandom(), $urandom()});
      bus.pushData  = tmp;
      bus.popReady  = ($urandom_range(1) == 1) || (sent == 600);
      @(negedge clk);
      if (bus.pushValid && bus.pushReady) sent++;
      tick();
    end
    bus.pushValid = 1'b0;
    bus.popReady  = 1'b0;
    check("wrap_sent", sent, 600);
    check("wrap_count", count, 0);
    check("wrap_wr_seen", (wr_wraps > 0), 1);
    check("wrap_rd_seen", (rd_wraps > 0), 1);

    // ---- Reset with 10 entries held and a read in flight -----------------
    accepted = 0;
    for (int c = 0; c < 100 && accepted < 10; c++) begin
      bus.pushValid = 1'b1;
      bus.pushData  = data_t'(c + 'h500);
      @(negedge clk);
      if (bus.pushReady) accepted++;
      tick();
    end
    bus.pushValid = 1'b0;
    repeat (4) tick();
    check("prerst_count", count, 10);
    bus.popReady = 1'b1;
    @(negedge clk);
    check("prerst_read_issue", re, 1);
    tick();
    bus.popReady  = 1'b0;
    bus.pushValid = 1'b1;
    bus.pushData  = data_t'('h777);
    sb_on = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_pop_valid", bus.popValid, 0);
    check("midrst_count", count, 0);
    check("midrst_ram_we", we, 0);
    check("midrst_ram_re", re, 0);
    check("midrst_push_ready", bus.pushReady, 0);
    bus.pushValid = 1'b0;
    repeat (2) tick();
    model_q.delete();
    exp_aw = 0;
    exp_ar = 0;
    rst_n = 1'b1;
    sb_on = 1'b1;
    tick();
    check("postrst_push_ready", bus.pushReady, 1);
    bus.pushValid = 1'b1;
    bus.pushData  = data_t'('hABC);
    tick();
    bus.pushValid = 1'b0;
    for (int c = 0; c < 10 && !bus.popValid; c++) tick();
    check("postrst_pop_valid", bus.popValid, 1);
    check("postrst_pop_data", bus.popData, 'hABC);
    bus.popReady = 1'b1;
    tick();
    gaps = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.popValid) gaps++;
      tick();
    end
    bus.popReady = 1'b0;
    check("postrst_only_abc", gaps, 0);
    check("postrst_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
